// File: rtl/wb_fifo_bridge_if.sv
// wb_fifo_bridge_if: Wishbone classic slave bus between CPU and the FIFO bridge
interface wb_fifo_bridge_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0] sel;
  logic we;
  logic cyc;
  logic stb;
  logic ack;
  logic err;
  logic rty;
  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err, rty);
  modport slave (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_fifo_bridge.sv
// wb_fifo_bridge: multi-channel Wishbone slave bridging CPU accesses to FT-side FIFOs
module wb_fifo_bridge #(
  parameter int CHANNELS = 2,
  parameter int FT_DATA_WIDTH = 32,
  parameter int BLKCNT_WIDTH = 8,
  parameter int TIMEOUT = 15
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb_fifo_bridge_if.slave wb,
  input  logic [CHANNELS*FT_DATA_WIDTH-1:0] fifoin_data_i,
  input  logic [CHANNELS-1:0] fifoin_empty_i,
  input  logic [CHANNELS-1:0] fifoin_full_i,
  output logic [CHANNELS-1:0] fifoin_rd_o,
  output logic fifoin_clk_o,
  output logic fifoout_clk_o,
  output logic [FT_DATA_WIDTH-1:0] fifoout_data_o,
  input  logic [CHANNELS-1:0] fifoout_empty_i,
  input  logic [CHANNELS-1:0] fifoout_full_i,
  output logic [CHANNELS-1:0] fifoout_wr_o,
  output logic [CHANNELS*BLKCNT_WIDTH-1:0] fifoout_blkcnt_o,
  output logic irq_o
);
  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;
  state_t state, nxt;
  logic [7:0] wcnt, nxt_wcnt;
  logic go_ack, go_err, go_rty, req, bad, is_data, ready, pop_push, ctrl_wr, unused_ok;
  logic [1:0] ch, rsel;
  logic [3:0] in_empty, in_full, out_empty, out_full, ien, chsel;
  logic [FT_DATA_WIDTH-1:0] din [4];
  logic [BLKCNT_WIDTH-1:0] bc [4];
  logic [BLKCNT_WIDTH-1:0] blkcnt [CHANNELS];
  logic [CHANNELS-1:0] irq_en;
  logic [31:0] rdata;
  assign fifoin_clk_o = wb_clk_i;
  assign fifoout_clk_o = wb_clk_i;
  assign fifoout_data_o = wb.dat_w[FT_DATA_WIDTH-1:0];
  assign ch = wb.adr[5:4];
  assign rsel = wb.adr[3:2];
  // Channel-indexed views padded to the full 4-channel address space so a bad index reads zeros
  assign in_empty = 4'(fifoin_empty_i);
  assign in_full = 4'(fifoin_full_i);
  assign out_empty = 4'(fifoout_empty_i);
  assign out_full = 4'(fifoout_full_i);
  assign ien = 4'(irq_en);
  assign chsel = 4'b1 << ch;
  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < CHANNELS) begin : g_real
      assign din[c] = fifoin_data_i[c*FT_DATA_WIDTH +: FT_DATA_WIDTH];
      assign bc[c] = blkcnt[c];
      assign fifoout_blkcnt_o[c*BLKCNT_WIDTH +: BLKCNT_WIDTH] = blkcnt[c];
    end else begin : g_pad
      assign din[c] = '0;
      assign bc[c] = '0;
    end
  end
  assign bad = {30'b0, ch} >= 32'(CHANNELS);
  assign is_data = rsel == 2'd0;
  assign ready = wb.we ? !out_full[ch] : !in_empty[ch];
  assign req = wb.cyc & wb.stb & !wb_rst_i;
  assign rdata = rsel == 2'd0 ? 32'(din[ch])
               : rsel == 2'd1 ? {16'(bc[ch]), 11'b0, ien[ch], in_empty[ch], in_full[ch], out_empty[ch], out_full[ch]}
               : rsel == 2'd2 ? {30'b0, ien[ch], 1'b0} : 32'b0;
  assign pop_push = go_ack & is_data;
  assign fifoin_rd_o = (pop_push & !wb.we) ? chsel[CHANNELS-1:0] : '0;
  assign fifoout_wr_o = (pop_push & wb.we) ? chsel[CHANNELS-1:0] : '0;
  assign ctrl_wr = go_ack & wb.we & (rsel == 2'd2) & wb.sel[0];
  assign unused_ok = ^{wb.adr[31:6], wb.adr[1:0], wb.sel[3:1], wb.dat_w, chsel};
  // Next-state decode: termination is chosen on the cycle leaving IDLE or WAIT, strobes ride on go_ack
  always_comb begin
    nxt = state;
    nxt_wcnt = wcnt;
    go_ack = 1'b0;
    go_err = 1'b0;
    go_rty = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (bad) begin
          go_err = 1'b1;
          nxt = TERM;
        end else if (!is_data || ready) begin
          go_ack = 1'b1;
          nxt = TERM;
        end else begin
          nxt = WAIT;
          nxt_wcnt = 8'd1;
        end
      end
      WAIT: if (!req) nxt = IDLE;
      else if (ready) begin
        go_ack = 1'b1;
        nxt = TERM;
      end else if (wcnt == 8'(TIMEOUT)) begin
        go_rty = 1'b1;
        nxt = TERM;
      end else nxt_wcnt = wcnt + 8'd1;
      default: nxt = IDLE;
    endcase
  end
  // FSM state, one-cycle terminations, captured read data and level interrupt
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      wcnt <= '0;
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      wb.rty <= 1'b0;
      wb.dat_r <= '0;
      irq_o <= 1'b0;
    end else begin
      state <= nxt;
      wcnt <= nxt_wcnt;
      wb.ack <= go_ack;
      wb.err <= go_err;
      wb.rty <= go_rty;
      if (go_ack & !wb.we) wb.dat_r <= rdata;
      irq_o <= |(irq_en & ~fifoin_empty_i);
    end
  // CTRL writes: clear beats increment, irq_en loads from bit 2
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      for (int c = 0; c < CHANNELS; c++) blkcnt[c] <= '0;
      irq_en <= '0;
    end else if (ctrl_wr) begin
      for (int c = 0; c < CHANNELS; c++)
        if (chsel[c]) begin
          blkcnt[c] <= wb.dat_w[1] ? '0 : wb.dat_w[0] ? blkcnt[c] + 1'b1 : blkcnt[c];
          irq_en[c] <= wb.dat_w[2];
        end
    end
endmodule
